// File: rtl/csr_timer_multi.sv
// csr_timer_multi: multi-channel CSR compare timer with shared prescaler and per-channel irq
module csr_timer_multi #(
  parameter logic [11:0] BASE_ADDR = 12'hBC2,
  parameter int          CHANNELS  = 2,
  parameter int          WIDTH     = 32,
  parameter int          PRESCALE  = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                read,
  input  logic [2:0]          modify,
  input  logic [31:0]         wdata,
  input  logic [11:0]         addr,
  output logic [31:0]         rdata,
  output logic                valid,
  output logic [CHANNELS-1:0] irq,
  output logic                irq_any
);
  localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  logic [PW-1:0] pre_q, pre_d;
  logic          tick, addr_vld_q, mod_ok, unused_read;
  logic [11:0]   addr_q;
  logic [31:0]   rd_c [CHANNELS];
  logic [CHANNELS-1:0] hit;
  function automatic logic [31:0] apply(input logic [2:0] m, input logic [31:0] o, input logic [31:0] w);
    return m == 3'd1 ? w : m == 3'd2 ? o | w : m == 3'd3 ? o & ~w : o;
  endfunction
  assign unused_read = read;
  assign tick        = pre_q == PW'(PRESCALE - 1);
  assign pre_d       = tick ? '0 : pre_q + PW'(1);
  assign mod_ok      = modify != 3'd0 && modify < 3'd4;
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q      <= '0;
      addr_q     <= '0;
      addr_vld_q <= 1'b0;
    end else begin
      pre_q      <= pre_d;
      addr_q     <= addr;
      addr_vld_q <= 1'b1;
    end
  end
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    localparam logic [11:0] A0 = BASE_ADDR + 12'(3 * c);
    logic [WIDTH-1:0] cnt_q, cnt_d, cmp_q, cmp_d, cnt_hw;
    logic [3:0]       ctl_q, ctl_d, ctl_hw;
    logic             s_cnt, s_cmp, s_ctl, run, match;
    assign s_cnt  = addr_vld_q && addr_q == A0;
    assign s_cmp  = addr_vld_q && addr_q == A0 + 12'd1;
    assign s_ctl  = addr_vld_q && addr_q == A0 + 12'd2;
    assign run    = tick & ctl_q[0];
    assign match  = run && cnt_q == cmp_q;
    assign cnt_hw = !run ? cnt_q : match ? (ctl_q[1] ? '0 : cnt_q) : cnt_q + WIDTH'(1);
    // one-shot match drops EN; PENDING is sticky until software clears it
    assign ctl_hw = {ctl_q[3] | match, ctl_q[2], ctl_q[1], ctl_q[0] & ~(match & ~ctl_q[1])};
    // CTRL set/clear act on the hardware-updated fields so untouched bits keep hw behaviour
    always_comb begin
      cnt_d = s_cnt && mod_ok ? WIDTH'(apply(modify, 32'(cnt_q), wdata)) : cnt_hw;
      cmp_d = s_cmp && mod_ok ? WIDTH'(apply(modify, 32'(cmp_q), wdata)) : cmp_q;
      ctl_d = s_ctl && mod_ok ? 4'(apply(modify, 32'(ctl_hw), wdata)) | {match, 3'b000} : ctl_hw;
    end
    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_q <= '0;
        cmp_q <= '0;
        ctl_q <= '0;
      end else begin
        cnt_q <= cnt_d;
        cmp_q <= cmp_d;
        ctl_q <= ctl_d;
      end
    end
    assign rd_c[c] = s_cnt ? 32'(cnt_q) : s_cmp ? 32'(cmp_q) : s_ctl ? 32'(ctl_q) : 32'd0;
    assign hit[c]  = s_cnt | s_cmp | s_ctl;
    assign irq[c]  = ctl_q[3] & ctl_q[2];
  end
  always_comb begin
    rdata = '0;
    for (int i = 0; i < CHANNELS; i++) rdata = rdata | rd_c[i];
  end
  assign valid   = |hit;
  assign irq_any = |irq;
endmodule
